// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//
// AXI4 slave that fronts a single-port word SRAM macro. One transaction is
// in flight at a time; INCR bursts of up to 2^LEN_W beats are translated
// into one SRAM access per beat. Reads run at one beat per cycle when the
// master keeps RREADY high; writes take one beat per WVALID cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   AW*_S / W*_S / B*_S AXI write address, write data, write response
//   AR*_S / R*_S        AXI read address, read data
//                       (AxSIZE/AxBURST are accepted but ignored:
//                        always 4-byte INCR)
//   sram_ceb            chip enable, active-low
//   sram_web            0 = write, 1 = read
//   sram_bweb           bit write enable, active-low
//   sram_a, sram_di     word address, write data
//   sram_do             read data, valid the cycle after a read access and
//                       held while the macro is not enabled
//
// WSTRB is active-low on this interconnect (0 = byte written), so it maps
// straight onto the active-low bit write enables.

module sram_axi_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ID_W-1:0]   AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [LEN_W-1:0]  AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,

  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,

  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,

  input  logic [ID_W-1:0]   ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [LEN_W-1:0]  ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,

  output logic [ID_W-1:0]   RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,

  output logic              sram_ceb,
  output logic              sram_web,
  output logic [31:0]       sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDATA = 2'd1,
    WDATA = 2'd2,
    WRESP = 2'd3
  } state_e;

  state_e             state_q, state_d;
  // Held low through reset so AR/AW readiness first appears after a clock
  // edge with rst_n released.
  logic               en_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_q, err_d;

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic last_beat;

  // Fields the slave deliberately ignores.
  logic unused_ok;
  assign unused_ok = ^{AWSIZE_S, AWBURST_S, ARSIZE_S, ARBURST_S,
                       AWADDR_S[31:ADDR_W+2], AWADDR_S[1:0],
                       ARADDR_S[31:ADDR_W+2], ARADDR_S[1:0]};

  assign last_beat = (cnt_q == len_q);

  // Reads have fixed priority over writes in IDLE.
  assign ARREADY_S = en_q && (state_q == IDLE);
  assign AWREADY_S = en_q && (state_q == IDLE) && !ARVALID_S;

  assign RVALID_S  = (state_q == RDATA);
  assign RDATA_S   = sram_do;
  assign RID_S     = id_q;
  assign RRESP_S   = 2'b00;
  assign RLAST_S   = RVALID_S && last_beat;

  assign WREADY_S  = (state_q == WDATA);

  assign BVALID_S  = (state_q == WRESP);
  assign BID_S     = id_q;
  assign BRESP_S   = (BVALID_S && err_q) ? 2'b10 : 2'b00;

  assign ar_hs = ARVALID_S && ARREADY_S;
  assign aw_hs = AWVALID_S && AWREADY_S;
  assign r_hs  = RVALID_S  && RREADY_S;
  assign w_hs  = WVALID_S  && WREADY_S;
  assign b_hs  = BVALID_S  && BREADY_S;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;

    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          id_d     = ARID_S;
          len_d    = ARLEN_S;
          cnt_d    = '0;
          addr_d   = ARADDR_S[ADDR_W+1:2];
          // First beat is fetched in the handshake cycle so RVALID can
          // follow on the next cycle.
          sram_ceb = 1'b0;
          sram_a   = ARADDR_S[ADDR_W+1:2];
          state_d  = RDATA;
        end else if (aw_hs) begin
          id_d     = AWID_S;
          len_d    = AWLEN_S;
          cnt_d    = '0;
          addr_d   = AWADDR_S[ADDR_W+1:2];
          state_d  = WDATA;
        end
      end

      RDATA: begin
        // Without a handshake the macro stays disabled, which keeps
        // sram_do (and so RDATA) stable through a stall.
        if (r_hs) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d   = addr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
            sram_ceb = 1'b0;
            sram_a   = addr_q + 1'b1;
          end
        end
      end

      WDATA: begin
        if (w_hs) begin
          sram_ceb  = 1'b0;
          sram_web  = 1'b0;
          sram_a    = addr_q;
          sram_di   = WDATA_S;
          sram_bweb = {{8{WSTRB_S[3]}}, {8{WSTRB_S[2]}},
                       {8{WSTRB_S[1]}}, {8{WSTRB_S[0]}}};
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
          // The beat count decides the burst end; WLAST only feeds the
          // error flag when it disagrees with the count.
          if (WLAST_S != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRESP;
          end
        end
      end

      WRESP: begin
        if (b_hs) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule
